// File: rtl/mips32_pkg.sv
// Shared types for the mips32 program loader. The CSUM state exists only when
// LOADER_CHECKSUM_EN is defined.
package mips32_pkg;

  localparam int ADDR_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_BASE = 3'd1,
    HDR_LEN  = 3'd2,
    DATA     = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    CSUM     = 3'd4,
`endif
    DONE     = 3'd5,
    ERR      = 3'd6
  } loader_state_t;

endpackage

// File: rtl/mips32_loader_wordasm.sv
// Packs accepted bytes (most significant first) into 32-bit words; word_valid
// pulses in the same cycle the fourth byte is accepted, with word already complete.
module mips32_loader_wordasm (
  input  logic        clk1,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  in_data,
  input  logic        accept,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk1) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk1) begin
    if (accept) begin
      shift_q <= {shift_q[15:0], in_data};
    end
  end

  assign word_valid = accept && (cnt_q == 2'd3);
  assign word       = {shift_q, in_data};

endmodule

// File: rtl/mips32_loader.sv
// Serial program loader for the mips32 core: header (base, len), data words and,
// with LOADER_CHECKSUM_EN defined, an XOR checksum trailer.
module mips32_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_DATA = CSUM;
`else
  localparam loader_state_t AFTER_DATA = DONE;
`endif
  localparam logic [ADDR_W+1:0] DEPTH = {2'b01, {ADDR_W{1'b0}}};

  loader_state_t     state_q;
  logic [ADDR_W-1:0] base_q;
  logic              base_hi_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W+1:0] span;
  logic [31:0]       word;
  logic              word_valid;
  logic              accept;
  logic              restart;
  logic              hdr_bad;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       csum_q;
`endif

  assign in_ready  = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
  assign core_hold = (state_q != DONE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign accept    = in_valid && in_ready;
  assign restart   = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

  // Range check uses a widened sum so base+len can never wrap; len bits above
  // ADDR_W already exceed any legal size on their own.
  assign span      = {2'b00, base_q} + {1'b0, word[ADDR_W:0]};
  assign hdr_bad   = base_hi_q || (|word[31:ADDR_W+1]) || (span > DEPTH);
  assign idx_inc   = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (idx_inc == len_q);

  mips32_loader_wordasm u_wordasm (
    .clk1       (clk1),
    .rst        (rst),
    .clr        (restart),
    .in_data    (in_data),
    .accept     (accept),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      idx_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        state_q <= HDR_BASE;
        idx_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_q  <= '0;
`endif
      end else begin
        case (state_q)
          HDR_BASE: if (word_valid) begin
            base_q    <= word[ADDR_W-1:0];
            base_hi_q <= |word[31:ADDR_W];
            state_q   <= HDR_LEN;
          end
          HDR_LEN: if (word_valid) begin
            len_q <= word[ADDR_W:0];
            idx_q <= '0;
            if (hdr_bad)              state_q <= ERR;
            else if (word == 32'd0)   state_q <= AFTER_DATA;
            else                      state_q <= DATA;
          end
          DATA: if (word_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= base_q + idx_q;
            mem_wdata <= word;
            idx_q     <= idx_inc[ADDR_W-1:0];
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= csum_q ^ word;
`endif
            if (last_word) state_q <= AFTER_DATA;
          end
`ifdef LOADER_CHECKSUM_EN
          CSUM: if (word_valid) begin
            state_q <= (word == csum_q) ? DONE : ERR;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips32_loader.sv
// Directed table-driven bench for mips32_loader; follows LOADER_CHECKSUM_EN to
// decide whether trailers are sent and what a bad trailer should produce.
module tb_mips32_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk1, rst, start, in_valid, in_ready, mem_we, core_hold, done, err;
  logic [7:0]  in_data;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;

  mips32_loader #(.ADDR_W(10)) dut (
    .clk1(clk1), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .err(err)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic [31:0] mem [0:1023];
  int          we_total = 0;
  always @(posedge clk1) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_total      <= we_total + 1;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] dwords [0:31];
  int          nwords;

  logic [31:0] prog [0:23] = '{
    32'h28010063, 32'h20020000, 32'h2003000a, 32'h00031880,
    32'h00621820, 32'h2463fffc, 32'h8c440000, 32'h8c650000,
    32'hac450000, 32'hac640000, 32'h24420004, 32'h2463fffc,
    32'h0043302a, 32'h14c0fff8, 32'h00000000, 32'h20070001,
    32'h00e73820, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'hfc000000
  };

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [31:0] len;
    int          dsel;
    bit          gap;
    bit          hdr_only;
    logic        exp_done;
    logic        exp_err;
    int          exp_we;
    int          a0;
    logic [31:0] v0;
    int          a1;
    logic [31:0] v1;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_data(input int dsel);
    if (dsel == 0) begin
      nwords = 24;
      for (int i = 0; i < 24; i++) dwords[i] = prog[i];
    end else if (dsel == 1) begin
      nwords = 5;
      dwords[0] = 32'd4;  dwords[1] = 32'd10; dwords[2] = 32'd20;
      dwords[3] = 32'd30; dwords[4] = 32'd40;
    end else begin
      nwords = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    @(negedge clk1);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk1);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: in_ready 0 after %0d cycles, expected 1", n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk1);
    if (gap) begin
      @(negedge clk1);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic pulse_start();
    @(negedge clk1);
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
  endtask

  task automatic run(input logic [31:0] base, input logic [31:0] len,
                     input logic [31:0] adj, input bit gap, input bit hdr_only);
    logic [31:0] cs;
    cs = adj;
    pulse_start();
    send_word(base, gap);
    send_word(len, gap);
    if (!hdr_only) begin
      for (int i = 0; i < nwords; i++) begin
        send_word(dwords[i], gap);
        cs = cs ^ dwords[i];
      end
      if (CSUM_ON) send_word(cs, gap);
    end
    @(negedge clk1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    vecs[0] = '{"prog",      32'd0,        32'd24, 0, 1'b0, 1'b0, 1'b1, 1'b0, 24, 0,    32'h28010063, 23,   32'hfc000000};
    vecs[1] = '{"gappy",     32'd99,       32'd5,  1, 1'b1, 1'b0, 1'b1, 1'b0, 5,  99,   32'd4,        103,  32'd40};
    vecs[2] = '{"overflow",  32'd1020,     32'd8,  2, 1'b0, 1'b1, 1'b0, 1'b1, 0,  -1,   32'd0,        -1,   32'd0};
    vecs[3] = '{"len0",      32'd0,        32'd0,  2, 1'b0, 1'b0, 1'b1, 1'b0, 0,  -1,   32'd0,        -1,   32'd0};
    vecs[4] = '{"base_hi",   32'h00000400, 32'd1,  2, 1'b0, 1'b1, 1'b0, 1'b1, 0,  -1,   32'd0,        -1,   32'd0};
    vecs[5] = '{"exact_fit", 32'd1019,     32'd5,  1, 1'b0, 1'b0, 1'b1, 1'b0, 5,  1019, 32'd4,        1023, 32'd40};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk1);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    rst = 1'b0;
    @(negedge clk1);

    for (int v = 0; v < 6; v++) begin
      load_data(vecs[v].dsel);
      we0 = we_total;
      run(vecs[v].base, vecs[v].len, 32'd0, vecs[v].gap, vecs[v].hdr_only);
      check({vecs[v].name, "_done"},      32'(done),           32'(vecs[v].exp_done));
      check({vecs[v].name, "_err"},       32'(err),            32'(vecs[v].exp_err));
      check({vecs[v].name, "_core_hold"}, 32'(core_hold),      32'(!vecs[v].exp_done));
      check({vecs[v].name, "_in_ready"},  32'(in_ready),       32'd0);
      check({vecs[v].name, "_we_count"},  32'(we_total - we0), 32'(vecs[v].exp_we));
      if (vecs[v].a0 >= 0) begin
        check({vecs[v].name, "_mem_a0"}, mem[vecs[v].a0], vecs[v].v0);
        check({vecs[v].name, "_mem_a1"}, mem[vecs[v].a1], vecs[v].v1);
      end
    end
    check("gappy_mem_mid", mem[101], 32'd20);
    check("prog_mem_mid",  mem[12],  prog[12]);

    // Bad checksum trailer, then a clean retry from the resulting state
    load_data(1);
    we0 = we_total;
    run(32'd200, 32'd5, 32'd1, 1'b0, 1'b0);
    check("badcs_err",      32'(err),            32'(CSUM_ON));
    check("badcs_done",     32'(done),           32'(!CSUM_ON));
    check("badcs_we_count", 32'(we_total - we0), 32'd5);
    check("badcs_mem_lo",   mem[200],            32'd4);
    check("badcs_mem_hi",   mem[204],            32'd40);
    run(32'd200, 32'd5, 32'd0, 1'b0, 1'b0);
    check("retry_done", 32'(done), 32'd1);
    check("retry_err",  32'(err),  32'd0);

    // Reset after two of five data words
    we0 = we_total;
    pulse_start();
    send_word(32'd300, 1'b0);
    send_word(32'd5, 1'b0);
    send_word(dwords[0], 1'b0);
    send_word(dwords[1], 1'b0);
    @(negedge clk1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    check("midrst_in_ready",  32'(in_ready),  32'd0);
    check("midrst_mem_we",    32'(mem_we),    32'd0);
    check("midrst_mem_addr",  32'(mem_addr),  32'd0);
    check("midrst_mem_wdata", mem_wdata,      32'd0);
    check("midrst_core_hold", 32'(core_hold), 32'd1);
    check("midrst_done",      32'(done),      32'd0);
    check("midrst_err",       32'(err),       32'd0);
    in_valid = 1'b1;
    in_data  = 8'h5a;
    repeat (10) @(negedge clk1);
    check("midrst_idle_ready", 32'(in_ready),       32'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk1);
    check("midrst_we_count",  32'(we_total - we0), 32'd2);
    check("midrst_mem0",      mem[300],            32'd4);
    check("midrst_mem1",      mem[301],            32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
